// File: rtl/mac_array_feeder.sv
// mac_array_feeder: buffers an A matrix (LANES x K) and a B vector (K), then drives a row of
// MAC lanes with systolic skew (lane i lags lane 0 by i cycles), including each lane's flush enable.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a compute pass (IDLE only)
//   wr_en, wr_sel     operand write strobe (IDLE only); 0 = A buffer, 1 = B buffer
//   wr_lane, wr_addr  A row index (ignored for B), element index
//   wr_data           operand value
//   mac_clr, mac_en   per-lane MAC Clr / En
//   mac_a, mac_b      per-lane Ain / Bin, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy, done        high outside IDLE; one-cycle pulse when all sums are final
module mac_array_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int K          = 8,
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1,
    localparam int KW = K > 1 ? $clog2(K) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [LW-1:0]               wr_lane,
    input  logic [KW-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [LANES-1:0]            mac_clr,
    output logic [LANES-1:0]            mac_en,
    output logic [LANES*DATA_WIDTH-1:0] mac_a,
    output logic [LANES*DATA_WIDTH-1:0] mac_b,
    output logic                        busy,
    output logic                        done
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(K + LANES + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic                    run_nxt;
    logic [DW-1:0]           a_buf [LANES][K];
    logic [DW-1:0]           b_buf [K];
    logic [LANES-1:0]        clr_nxt, en_nxt;
    logic [LANES*DW-1:0]     a_nxt, b_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++)
                for (int j = 0; j < K; j++)
                    a_buf[i][j] <= '0;
            for (int j = 0; j < K; j++)
                b_buf[j] <= '0;
        end else if (state == IDLE && wr_en) begin
            if (wr_sel) begin
                if (int'(wr_addr) < K)
                    b_buf[wr_addr] <= wr_data;
            end else if (int'(wr_lane) < LANES && int'(wr_addr) < K) begin
                a_buf[wr_lane][wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:    state_nxt = start ? CLEAR : IDLE;
            CLEAR: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
            RUN: begin
                if (int'(cnt) == K + LANES - 1)
                    state_nxt = DONE;
                else
                    cnt_nxt = cnt + CW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run_nxt = state_nxt == RUN;

    // Outputs are computed for the cycle the FSM is about to enter. Lane 0 sees the B stream
    // and enable window (K operands plus one flush); higher lanes take both from their lower
    // neighbour's registered output, which yields the one-cycle-per-lane skew.
    always_comb begin
        clr_nxt = {LANES{state_nxt == CLEAR}};
        en_nxt  = '0;
        a_nxt   = '0;
        b_nxt   = '0;
        en_nxt[0]     = run_nxt && int'(cnt_nxt) <= K;
        b_nxt[DW-1:0] = (run_nxt && int'(cnt_nxt) < K) ? b_buf[cnt_nxt[KW-1:0]] : '0;
        for (int i = 1; i < LANES; i++) begin
            en_nxt[i]         = mac_en[i-1];
            b_nxt[i*DW +: DW] = mac_b[(i-1)*DW +: DW];
        end
        for (int i = 0; i < LANES; i++)
            if (run_nxt && int'(cnt_nxt) >= i && int'(cnt_nxt) - i < K)
                a_nxt[i*DW +: DW] = a_buf[i][KW'(int'(cnt_nxt) - i)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mac_clr <= '0;
            mac_en  <= '0;
            mac_a   <= '0;
            mac_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mac_clr <= clr_nxt;
            mac_en  <= en_nxt;
            mac_a   <= a_nxt;
            mac_b   <= b_nxt;
            busy    <= state_nxt != IDLE;
            done    <= state_nxt == DONE;
        end
    end
endmodule
